// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match controller: FSM states, winner codes,
// serve directions and the default score width.
package pong_pkg;

  localparam int DEFAULT_SCORE_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_RUNNING    = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam logic SERVE_TO_P1 = 1'b0;
  localparam logic SERVE_TO_P2 = 1'b1;

endpackage

// File: rtl/pong_serve_timer.sv
// Serve delay counter: counts enabled cycles and flags the last one, then wraps
// to zero. Holding i_Enable low freezes the count; i_Clear forces it to zero.
module pong_serve_timer #(
  parameter int c_SERVE_DELAY = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Done
);

  localparam int CW = (c_SERVE_DELAY > 1) ? $clog2(c_SERVE_DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(c_SERVE_DELAY - 1);

  logic [CW-1:0] count_reg;

  assign o_Done = (count_reg == LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_reg <= '0;
    end else if (i_Clear) begin
      count_reg <= '0;
    end else if (i_Enable) begin
      count_reg <= o_Done ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: start/serve/rally/point/game-over FSM with score keeping.
// Optional pause input and behaviour are built when PONG_PAUSE_EN is defined.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int c_SERVE_DELAY = 25000000,
  parameter int c_WIN_SCORE   = 9,
  parameter int c_SCORE_WIDTH = DEFAULT_SCORE_WIDTH
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     i_Start,
  input  logic                     i_P1_Miss,
  input  logic                     i_P2_Miss,
`ifdef PONG_PAUSE_EN
  input  logic                     i_Pause,
`endif
  output logic                     o_Game_Active,
  output logic                     o_Ball_Reset,
  output logic                     o_Serve_Dir,
  output logic [c_SCORE_WIDTH-1:0] o_P1_Score,
  output logic [c_SCORE_WIDTH-1:0] o_P2_Score,
  output logic [1:0]               o_Winner,
  output logic [2:0]               o_State
);

  localparam logic [c_SCORE_WIDTH-1:0] WIN = c_SCORE_WIDTH'(c_WIN_SCORE);

  state_t                   state_reg, state_next;
  logic [c_SCORE_WIDTH-1:0] p1_reg, p1_next;
  logic [c_SCORE_WIDTH-1:0] p2_reg, p2_next;
  winner_t                  winner_reg, winner_next;
  logic                     dir_reg, dir_next;
  logic                     ball_reset_reg, ball_reset_next;
  logic                     active_reg, active_next;
  logic                     start_d_reg;
  logic                     start_rise;
  logic                     hold;
  logic                     timer_done;

  assign start_rise = i_Start & ~start_d_reg;

`ifdef PONG_PAUSE_EN
  logic pause_d_reg;
  logic paused_reg, paused_next;
  logic pause_rise;

  assign pause_rise = i_Pause & ~pause_d_reg;
  // Toggled value gates this cycle's decisions so the counter freezes on the press edge.
  assign hold       = paused_reg ^ pause_rise;

  always_comb begin
    paused_next = hold;
    if (state_next == ST_IDLE || state_next == ST_GAME_OVER)
      paused_next = 1'b0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pause_d_reg <= 1'b0;
      paused_reg  <= 1'b0;
    end else begin
      pause_d_reg <= i_Pause;
      paused_reg  <= paused_next;
    end
  end

  assign active_next = (state_next == ST_RUNNING) && !paused_next;
`else
  assign hold        = 1'b0;
  assign active_next = (state_next == ST_RUNNING);
`endif

  pong_serve_timer #(
    .c_SERVE_DELAY(c_SERVE_DELAY)
  ) u_timer (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Enable(state_reg == ST_SERVE_WAIT && !hold),
    .i_Clear (state_reg != ST_SERVE_WAIT),
    .o_Done  (timer_done)
  );

  always_comb begin
    state_next      = state_reg;
    p1_next         = p1_reg;
    p2_next         = p2_reg;
    winner_next     = winner_reg;
    dir_next        = dir_reg;
    ball_reset_next = 1'b0;

    case (state_reg)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          p1_next         = '0;
          p2_next         = '0;
          winner_next     = WIN_NONE;
          dir_next        = SERVE_TO_P1;
          ball_reset_next = 1'b1;
          state_next      = ST_SERVE_WAIT;
        end
      end

      ST_SERVE_WAIT: begin
        if (!hold && timer_done)
          state_next = ST_RUNNING;
      end

      ST_RUNNING: begin
        if (!hold) begin
          if (i_P1_Miss && !i_P2_Miss) begin
            if (p2_reg < WIN)
              p2_next = p2_reg + 1'b1;
            dir_next   = SERVE_TO_P1;
            state_next = ST_POINT;
          end else if (i_P2_Miss && !i_P1_Miss) begin
            if (p1_reg < WIN)
              p1_next = p1_reg + 1'b1;
            dir_next   = SERVE_TO_P2;
            state_next = ST_POINT;
          end else if (i_P1_Miss && i_P2_Miss) begin
            // Simultaneous misses are a replay: no score, serve direction kept.
            state_next = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        if (p1_reg == WIN) begin
          winner_next = WIN_P1;
          state_next  = ST_GAME_OVER;
        end else if (p2_reg == WIN) begin
          winner_next = WIN_P2;
          state_next  = ST_GAME_OVER;
        end else begin
          ball_reset_next = 1'b1;
          state_next      = ST_SERVE_WAIT;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg      <= ST_IDLE;
      p1_reg         <= '0;
      p2_reg         <= '0;
      winner_reg     <= WIN_NONE;
      dir_reg        <= 1'b0;
      ball_reset_reg <= 1'b0;
      active_reg     <= 1'b0;
      start_d_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      p1_reg         <= p1_next;
      p2_reg         <= p2_next;
      winner_reg     <= winner_next;
      dir_reg        <= dir_next;
      ball_reset_reg <= ball_reset_next;
      active_reg     <= active_next;
      start_d_reg    <= i_Start;
    end
  end

  assign o_Game_Active = active_reg;
  assign o_Ball_Reset  = ball_reset_reg;
  assign o_Serve_Dir   = dir_reg;
  assign o_P1_Score    = p1_reg;
  assign o_P2_Score    = p2_reg;
  assign o_Winner      = winner_reg;
  assign o_State       = state_reg;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with a 4-cycle serve delay and first-to-3 scoring.
// Pause scenario is exercised when PONG_PAUSE_EN is defined.
module tb_pong_match_ctrl;

  localparam int DELAY = 4;
  localparam int WIN   = 3;
  localparam int W     = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         p1_miss = 1'b0;
  logic         p2_miss = 1'b0;
  logic         active, ball_reset, serve_dir;
  logic [W-1:0] p1_score, p2_score;
  logic [1:0]   winner;
  logic [2:0]   state;
`ifdef PONG_PAUSE_EN
  logic         pause = 1'b0;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .c_SERVE_DELAY(DELAY),
    .c_WIN_SCORE  (WIN),
    .c_SCORE_WIDTH(W)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Start      (start),
    .i_P1_Miss    (p1_miss),
    .i_P2_Miss    (p2_miss),
`ifdef PONG_PAUSE_EN
    .i_Pause      (pause),
`endif
    .o_Game_Active(active),
    .o_Ball_Reset (ball_reset),
    .o_Serve_Dir  (serve_dir),
    .o_P1_Score   (p1_score),
    .o_P2_Score   (p2_score),
    .o_Winner     (winner),
    .o_State      (state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [16:0] all_out;
    rst_n = 1'b0;
    tick(3);
    all_out = {active, ball_reset, serve_dir, p1_score, p2_score, winner, state};
    total++;
    if (all_out !== 17'd0) $display("FAIL reset_outputs got %h exp 0", all_out);
    else passed++;
    rst_n = 1'b1;
    tick(2);
    total++;
    if (state !== 3'd0) $display("FAIL idle_after_reset state got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_start;
    start = 1'b1;
    tick(1);
    total++;
    if ({ball_reset, state, active} !== {1'b1, 3'd1, 1'b0})
      $display("FAIL start_pulse ball_reset/state/active got %b/%0d/%b exp 1/1/0", ball_reset, state, active);
    else passed++;
    $display("start: ball_reset=%b state=%0d", ball_reset, state);
    tick(1);
    total++;
    if (ball_reset !== 1'b0) $display("FAIL ball_reset_one_cycle got %b exp 0", ball_reset);
    else passed++;
    tick(2);
    total++;
    if ({active, state} !== {1'b0, 3'd1})
      $display("FAIL serve_wait_hold active/state got %b/%0d exp 0/1", active, state);
    else passed++;
    tick(1);
    total++;
    if ({active, state} !== {1'b1, 3'd2})
      $display("FAIL running_entry active/state got %b/%0d exp 1/2", active, state);
    else passed++;
    $display("serve done: active=%b state=%0d", active, state);
  endtask

  task automatic test_p1_miss;
    p1_miss = 1'b1;
    tick(1);
    p1_miss = 1'b0;
    total++;
    if ({state, p1_score, p2_score, serve_dir, active} !== {3'd3, 4'd0, 4'd1, 1'b0, 1'b0})
      $display("FAIL p1_miss_point state/p1/p2/dir/active got %0d/%0d/%0d/%b/%b exp 3/0/1/0/0",
               state, p1_score, p2_score, serve_dir, active);
    else passed++;
    tick(1);
    total++;
    if ({state, ball_reset} !== {3'd1, 1'b1})
      $display("FAIL p1_miss_reserve state/ball_reset got %0d/%b exp 1/1", state, ball_reset);
    else passed++;
    tick(3);
    total++;
    if (active !== 1'b0) $display("FAIL p1_miss_still_serving active got %b exp 0", active);
    else passed++;
    tick(1);
    total++;
    if ({active, state} !== {1'b1, 3'd2})
      $display("FAIL p1_miss_resume active/state got %b/%0d exp 1/2", active, state);
    else passed++;
    $display("p1 miss: score %0d-%0d dir=%b", p1_score, p2_score, serve_dir);
  endtask

  task automatic test_p2_miss;
    p2_miss = 1'b1;
    tick(1);
    p2_miss = 1'b0;
    total++;
    if ({p1_score, p2_score, serve_dir} !== {4'd1, 4'd1, 1'b1})
      $display("FAIL p2_miss_score p1/p2/dir got %0d/%0d/%b exp 1/1/1", p1_score, p2_score, serve_dir);
    else passed++;
    tick(5);
    total++;
    if (state !== 3'd2) $display("FAIL p2_miss_resume state got %0d exp 2", state);
    else passed++;
    $display("p2 miss: score %0d-%0d dir=%b", p1_score, p2_score, serve_dir);
  endtask

  task automatic test_both_miss;
    p1_miss = 1'b1;
    p2_miss = 1'b1;
    tick(1);
    p1_miss = 1'b0;
    p2_miss = 1'b0;
    total++;
    if ({state, p1_score, p2_score, serve_dir} !== {3'd3, 4'd1, 4'd1, 1'b1})
      $display("FAIL both_miss_point state/p1/p2/dir got %0d/%0d/%0d/%b exp 3/1/1/1",
               state, p1_score, p2_score, serve_dir);
    else passed++;
    tick(1);
    total++;
    if ({state, ball_reset} !== {3'd1, 1'b1})
      $display("FAIL both_miss_replay state/ball_reset got %0d/%b exp 1/1", state, ball_reset);
    else passed++;
    tick(4);
    total++;
    if (active !== 1'b1) $display("FAIL both_miss_resume active got %b exp 1", active);
    else passed++;
    $display("replay: score %0d-%0d dir=%b", p1_score, p2_score, serve_dir);
  endtask

  task automatic test_win;
    int pulses;
    p2_miss = 1'b1;
    tick(1);
    p2_miss = 1'b0;
    tick(5);
    p2_miss = 1'b1;
    tick(1);
    p2_miss = 1'b0;
    total++;
    if ({state, p1_score} !== {3'd3, 4'd3})
      $display("FAIL win_point state/p1 got %0d/%0d exp 3/3", state, p1_score);
    else passed++;
    tick(1);
    total++;
    if ({state, winner, ball_reset, active} !== {3'd4, 2'b01, 1'b0, 1'b0})
      $display("FAIL game_over state/winner/ball_reset/active got %0d/%b/%b/%b exp 4/01/0/0",
               state, winner, ball_reset, active);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (ball_reset) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL game_over_no_ball_reset got %0d exp 0", pulses);
    else passed++;
    p1_miss = 1'b1;
    tick(1);
    p1_miss = 1'b0;
    tick(1);
    total++;
    if ({state, p1_score, p2_score, winner} !== {3'd4, 4'd3, 4'd1, 2'b01})
      $display("FAIL game_over_ignores_miss state/p1/p2/winner got %0d/%0d/%0d/%b exp 4/3/1/01",
               state, p1_score, p2_score, winner);
    else passed++;
    $display("game over: score %0d-%0d winner=%b", p1_score, p2_score, winner);
  endtask

  task automatic test_hold_start;
    int pulses;
    // Start has been held since the first serve, so no new edge exists yet.
    tick(3);
    total++;
    if (state !== 3'd4) $display("FAIL held_start_no_restart state got %0d exp 4", state);
    else passed++;
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
    total++;
    if ({state, p1_score, p2_score, winner, serve_dir, ball_reset} !== {3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1})
      $display("FAIL restart_clear state/p1/p2/winner/dir/ball_reset got %0d/%0d/%0d/%b/%b/%b exp 1/0/0/00/0/1",
               state, p1_score, p2_score, winner, serve_dir, ball_reset);
    else passed++;
    rst_n = 1'b0;
    tick(1);
    start = 1'b0;
    rst_n = 1'b1;
    tick(1);
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ball_reset) pulses++;
    end
    total++;
    if ({pulses, state} !== {32'd1, 3'd2})
      $display("FAIL hold_start_once pulses/state got %0d/%0d exp 1/2", pulses, state);
    else passed++;
    $display("hold start 100 cycles: ball_reset pulses=%0d state=%0d", pulses, state);
  endtask

  task automatic test_async_reset;
    logic [16:0] all_out;
    p2_miss = 1'b1;
    tick(1);
    p2_miss = 1'b0;
    tick(2);
    total++;
    if ({state, p1_score} !== {3'd1, 4'd1})
      $display("FAIL pre_reset_serve state/p1 got %0d/%0d exp 1/1", state, p1_score);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    all_out = {active, ball_reset, serve_dir, p1_score, p2_score, winner, state};
    total++;
    if (all_out !== 17'd0) $display("FAIL async_reset_outputs got %h exp 0", all_out);
    else passed++;
    $display("async reset mid-serve: outputs=%h", all_out);
    start = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    total++;
    if (dut.u_timer.count_reg !== 2'd2) $display("FAIL pause_pre_count got %0d exp 2", dut.u_timer.count_reg);
    else passed++;
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    tick(50);
    total++;
    if ({dut.u_timer.count_reg, state, active} !== {2'd2, 3'd1, 1'b0})
      $display("FAIL pause_frozen count/state/active got %0d/%0d/%b exp 2/1/0",
               dut.u_timer.count_reg, state, active);
    else passed++;
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    total++;
    if (active !== 1'b0) $display("FAIL unpause_first_cycle active got %b exp 0", active);
    else passed++;
    tick(1);
    total++;
    if ({active, state} !== {1'b1, 3'd2})
      $display("FAIL unpause_resume active/state got %b/%0d exp 1/2", active, state);
    else passed++;
    $display("pause: resumed active=%b state=%0d", active, state);
  endtask
`endif

  initial begin
    test_reset;
    test_start;
    test_p1_miss;
    test_p2_miss;
    test_both_miss;
    test_win;
    test_hold_start;
    test_async_reset;
`ifdef PONG_PAUSE_EN
    test_pause;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong game. Gates the paddle and ball datapaths through o_Game_Active, re-centres the ball before each serve, keeps both players' scores and declares a winner. Sits between the board inputs (start button) and the per-player paddle controllers and the ball controller, and consumes the ball controller's miss pulses.

Parameters:
c_SERVE_DELAY, 25000000, clocks spent in SERVE_WAIT before play resumes (1 s at 25 MHz); must be >= 1.
c_WIN_SCORE, 9, points needed to win; must be < 2**c_SCORE_WIDTH.
c_SCORE_WIDTH, 4, width of each score counter.

Ports:
i_Clk  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Start  in  1  start button level (debounced upstream); edge-detected internally
i_P1_Miss  in  1  one-cycle pulse: ball passed player 1's edge, so the point goes to P2
i_P2_Miss  in  1  one-cycle pulse: ball passed player 2's edge, so the point goes to P1
o_Game_Active  out  1  high only in RUNNING; enables paddle movement and ball motion
o_Ball_Reset  out  1  one-cycle pulse: re-centre the ball
o_Serve_Dir  out  1  0 = serve toward P1, 1 = serve toward P2
o_P1_Score  out  c_SCORE_WIDTH  player 1 score
o_P2_Score  out  c_SCORE_WIDTH  player 2 score
o_Winner  out  2  00 none, 01 P1, 10 P2
o_State  out  3  current state encoding, for debug and display

Behaviour:
- Reset is asynchronous and active-low (i_Rst_n). On reset:
  - state = IDLE
  - all outputs 0
  - serve counter 0
  - start edge register 0
- Start edge: r_Start_d holds the previous i_Start. w_Start_Rise = i_Start & ~r_Start_d. Holding the button does not retrigger.
- States: IDLE=0, SERVE_WAIT=1, RUNNING=2, POINT=3, GAME_OVER=4. Unused codes return to IDLE.
- IDLE, on w_Start_Rise:
  - clear both scores, o_Winner=00, o_Serve_Dir=0
  - pulse o_Ball_Reset in the next cycle
  - go to SERVE_WAIT
- SERVE_WAIT:
  - counter increments from 0 each cycle.
  - When it equals c_SERVE_DELAY-1: clear the counter, go to RUNNING.
  - Miss pulses are ignored.
  - Latency from the start edge to o_Game_Active=1 is c_SERVE_DELAY+1 clocks.
- RUNNING: o_Game_Active=1.
  - i_P1_Miss alone: P2 score +1, o_Serve_Dir=0, go to POINT.
  - i_P2_Miss alone: P1 score +1, o_Serve_Dir=1, go to POINT.
  - Both in the same cycle: no score change, o_Serve_Dir unchanged, go to POINT (replay).
- POINT: lasts exactly one cycle, o_Game_Active=0.
  - Either score == c_WIN_SCORE: set o_Winner to that player, go to GAME_OVER (no ball reset).
  - Otherwise: pulse o_Ball_Reset in the next cycle and go to SERVE_WAIT.
- GAME_OVER:
  - scores and o_Winner hold
  - on w_Start_Rise, same actions as IDLE start
- Scores saturate at c_WIN_SCORE and never wrap.
- Asserting reset mid-serve or mid-rally returns to IDLE immediately; the scores are lost.
- All outputs are registered.

Optional Feature:
Macro PONG_PAUSE_EN.
- When defined:
  - adds input i_Pause (level, debounced upstream); its rising edge toggles r_Paused
  - while r_Paused=1 in SERVE_WAIT or RUNNING: o_Game_Active=0, the serve counter freezes, miss pulses are ignored
  - unpausing resumes the same state with the counter value intact
  - r_Paused clears on reset and on entry to IDLE or GAME_OVER
- When undefined: no i_Pause port, and behaviour is exactly as specified above.

Decomposition:
- Package pong_pkg:
  - state encodings
  - winner encodings (WIN_NONE/WIN_P1/WIN_P2)
  - serve direction constants
  - default c_SCORE_WIDTH
- Sub-module pong_serve_timer:
  - ports: clock, reset, enable, clear; output o_Done
  - o_Done is high on the cycle the count equals c_SERVE_DELAY-1
  - instantiated once

Test Plan:
1. Use c_SERVE_DELAY=4. Assert reset, release it, raise i_Start at cycle 10 → o_Ball_Reset pulses at cycle 11; o_Game_Active rises at cycle 15; o_State=2.
2. In RUNNING, pulse i_P1_Miss once → o_P2_Score=1, o_Serve_Dir=0, one POINT cycle, o_Ball_Reset pulse, o_Game_Active low for 4 cycles then high again.
3. Use c_WIN_SCORE=3. Deliver three i_P2_Miss pulses across serves → o_P1_Score=3, o_Winner=01, o_State=4, no further o_Ball_Reset; a later miss pulse changes nothing.
4. Pulse i_P1_Miss and i_P2_Miss in the same cycle at score 1–1 → scores stay 1–1, serve direction unchanged, replay serve occurs.
5. Hold i_Start high for 100 cycles from IDLE → exactly one start. Assert reset during SERVE_WAIT → o_State=0 and all outputs 0 asynchronously.
6. With PONG_PAUSE_EN defined, pulse i_Pause at serve-counter value 2, wait 50 cycles, pulse again → counter resumes at 2; o_Game_Active stays low throughout and rises 2 cycles after unpause.
